wave_meas_ctrl: RTL

Measurement sequencer for the zero-crossing wave analyzer. It pulses the analyzer's synchronous clear, waits until the analyzer's half-period count (freq) stops advancing, then samples freq/amp. It averages 2^AVG_LOG2 such measurements and presents one validated result with a 1-cycle strobe. Sits between the analyzer instance and the display/lookup logic, in single-shot or free-running mode.

---
 rtl/wave_meas_ctrl.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/wave_meas_ctrl.sv
// Measurement sequencer for the zero-crossing wave analyzer.
// Ports: clk/rst_n; start/cont/abort control; freq_in/amp_in from
// analyzer; ana_clr to analyzer; busy, res_valid, res_freq, res_amp,
// timeout to display/lookup logic.
module wave_meas_ctrl #(
  parameter int CLR_CYC     = 4,
  parameter int STABLE_CYC  = 64,
  parameter int TIMEOUT_CYC = 4000000,
  parameter int AVG_LOG2    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        cont,
  input  logic        abort,
  input  logic [21:0] freq_in,
  input  logic [11:0] amp_in,
  output logic        ana_clr,
  output logic        busy,
  output logic        res_valid,
  output logic [21:0] res_freq,
  output logic [11:0] res_amp,
  output logic        timeout
);

  localparam int CLW = $clog2(CLR_CYC + 1);
  localparam int CW  = $clog2(TIMEOUT_CYC + 1);
  localparam int SW  = $clog2(STABLE_CYC);
  localparam int MW  = AVG_LOG2 + 1;
  localparam int FAW = 22 + AVG_LOG2;
  localparam int AAW = 12 + AVG_LOG2;

  localparam logic [CLW-1:0] CLR_LAST = CLW'(CLR_CYC - 1);
  localparam logic [CW-1:0]  CYC_LAST = CW'(TIMEOUT_CYC - 1);
  localparam logic [SW-1:0]  STB_LAST = SW'(STABLE_CYC - 1);
  localparam logic [MW-1:0]  MEAS_N   = MW'(2 ** AVG_LOG2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t          state;
  logic [CLW-1:0]  clr_cnt;
  logic [CW-1:0]   cyc_cnt;
  logic [SW-1:0]   stb_cnt;
  logic [MW-1:0]   meas_cnt;
  logic [21:0]     prev_freq;
  logic [FAW-1:0]  freq_acc;
  logic [AAW-1:0]  amp_acc;

  logic [SW-1:0]   stb_cur;
  logic            stable_hit;
  logic            tmo_hit;
  logic [FAW-1:0]  f_sum;
  logic [AAW-1:0]  a_sum;
  logic [MW-1:0]   meas_nxt;
  logic            last_meas;

  // The first RUN cycle always counts as a fresh value: prev_freq then
  // still holds a sample taken while the analyzer was being cleared.
  always_comb begin
    stb_cur = '0;
    if (cyc_cnt != '0 && freq_in == prev_freq && freq_in != '0)
      stb_cur = stb_cnt + SW'(1);
    stable_hit = (stb_cur == STB_LAST);
    tmo_hit    = (cyc_cnt == CYC_LAST);
    f_sum      = freq_acc + FAW'(freq_in);
    a_sum      = amp_acc + AAW'(amp_in);
    meas_nxt   = meas_cnt + MW'(1);
    last_meas  = (meas_nxt == MEAS_N);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      clr_cnt   <= '0;
      cyc_cnt   <= '0;
      stb_cnt   <= '0;
      meas_cnt  <= '0;
      prev_freq <= '0;
      freq_acc  <= '0;
      amp_acc   <= '0;
      ana_clr   <= 1'b0;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      res_freq  <= '0;
      res_amp   <= '0;
      timeout   <= 1'b0;
    end else begin
      prev_freq <= freq_in;
      res_valid <= 1'b0;
      if (abort) begin
        state    <= S_IDLE;
        ana_clr  <= 1'b0;
        busy     <= 1'b0;
        freq_acc <= '0;
        amp_acc  <= '0;
        meas_cnt <= '0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (start) begin
              state    <= S_CLEAR;
              ana_clr  <= 1'b1;
              busy     <= 1'b1;
              timeout  <= 1'b0;
              freq_acc <= '0;
              amp_acc  <= '0;
              meas_cnt <= '0;
              clr_cnt  <= '0;
            end
          end
          S_CLEAR: begin
            if (clr_cnt == CLR_LAST) begin
              state   <= S_RUN;
              ana_clr <= 1'b0;
              cyc_cnt <= '0;
              stb_cnt <= '0;
            end else begin
              clr_cnt <= clr_cnt + CLW'(1);
            end
          end
          S_RUN: begin
            cyc_cnt <= cyc_cnt + CW'(1);
            stb_cnt <= stb_cur;
            if (stable_hit) begin
              state <= S_CAPTURE;
            end else if (tmo_hit) begin
              state   <= S_IDLE;
              busy    <= 1'b0;
              timeout <= 1'b1;
            end
          end
          S_CAPTURE: begin
            freq_acc <= f_sum;
            amp_acc  <= a_sum;
            meas_cnt <= meas_nxt;
            if (last_meas) begin
              state     <= S_DONE;
              res_valid <= 1'b1;
              res_freq  <= 22'(f_sum >> AVG_LOG2);
              res_amp   <= 12'(a_sum >> AVG_LOG2);
            end else begin
              state   <= S_CLEAR;
              ana_clr <= 1'b1;
              clr_cnt <= '0;
            end
          end
          S_DONE: begin
            if (cont) begin
              state    <= S_CLEAR;
              ana_clr  <= 1'b1;
              clr_cnt  <= '0;
              freq_acc <= '0;
              amp_acc  <= '0;
              meas_cnt <= '0;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
